// File: rtl/fetch_queue.sv
// Instruction fetch queue between Fetch and Decode: a DEPTH-entry circular
// buffer of {next-PC, instruction} pairs with a synchronous flush for squashes.
module fetch_queue #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [PC_W-1:0]            enq_npc,
  input  logic [INSTR_W-1:0]         enq_instr,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [PC_W-1:0]            deq_npc,
  output logic [INSTR_W-1:0]         deq_instr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  // Handshake: a transfer happens on a rising edge where valid && ready and
  // flush is low; ready never depends on valid, and valid never depends on ready.
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [PC_W-1:0]    npc_mem   [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic               enq_fire;
  logic               deq_fire;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];

  // Status comes from the registered pointers only, so no input reaches it.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_idx == rd_idx) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
  assign count     = wr_ptr - rd_ptr;
  assign enq_ready = !full;
  assign deq_valid = !empty;

  assign enq_fire = enq_valid && enq_ready && !flush;
  assign deq_fire = deq_valid && deq_ready && !flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (deq_fire) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Flush leaves storage intact; the empty mux below hides stale entries.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        npc_mem[i]   <= '0;
        instr_mem[i] <= '0;
      end
    end else if (enq_fire) begin
      npc_mem[wr_idx]   <= enq_npc;
      instr_mem[wr_idx] <= enq_instr;
    end
  end

  // Decode sees an all-zero word (NOP) whenever the queue is empty.
  assign deq_npc   = empty ? '0 : npc_mem[rd_idx];
  assign deq_instr = empty ? '0 : instr_mem[rd_idx];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4): reset, fill/stall,
// drain across the pointer wrap, simultaneous traffic, flush and async reset.
module tb_fetch_queue;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;

  logic               CLK;
  logic               nRST;
  logic               flush;
  logic               enq_valid;
  logic               enq_ready;
  logic [PC_W-1:0]    enq_npc;
  logic [INSTR_W-1:0] enq_instr;
  logic               deq_valid;
  logic               deq_ready;
  logic [PC_W-1:0]    deq_npc;
  logic [INSTR_W-1:0] deq_instr;
  logic [2:0]         count;
  logic               full;
  logic               empty;

  logic [PC_W-1:0] exp_q[$];
  int n_checks;
  int n_errors;

  fetch_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_npc(enq_npc), .enq_instr(enq_instr),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_npc(deq_npc), .deq_instr(deq_instr),
    .count(count), .full(full), .empty(empty)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] npc);
    return npc ^ 32'h00A0_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ev, input logic [PC_W-1:0] npc,
                       input logic dr, input logic fl);
    enq_valid = ev;
    enq_npc   = npc;
    enq_instr = instr_of(npc);
    deq_ready = dr;
    flush     = fl;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_empty"}, 64'(empty), 64'd1);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_enq_ready"}, 64'(enq_ready), 64'd1);
    check({tag, "_deq_valid"}, 64'(deq_valid), 64'd0);
    check({tag, "_full"}, 64'(full), 64'd0);
    check({tag, "_deq_npc"}, 64'(deq_npc), 64'd0);
    check({tag, "_deq_instr"}, 64'(deq_instr), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    nRST = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Reset then idle
    step();
    step();
    check_idle("reset");
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("idle");
    end

    // Fill with Decode stalled
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, PC_W'(4 * k), 1'b0, 1'b0);
      step();
      check("fill_count", 64'(count), 64'(k));
      check("fill_head", 64'(deq_npc), 64'h4);
    end
    check("fill_full", 64'(full), 64'd1);
    check("fill_enq_ready", 64'(enq_ready), 64'd0);
    drive(1'b1, 32'h14, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_count", 64'(count), 64'd4);
      check("stall_npc", 64'(deq_npc), 64'h4);
      check("stall_instr", 64'(deq_instr), 64'(instr_of(32'h4)));
    end

    // Drain the full queue; 0x14 must never show up
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check("drain_npc", 64'(deq_npc), 64'(4 * k));
      step();
    end
    check_idle("drained");

    // Continuous traffic across the pointer wrap: count steady at 1
    for (int i = 0; i <= 10; i++) begin
      drive(i < 10, PC_W'(4 * (i + 1)), 1'b1, 1'b0);
      if (i > 0) begin
        check("stream_count", 64'(count), 64'd1);
        if (exp_q.size() > 0) begin
          check("stream_npc", 64'(deq_npc), 64'(exp_q[0]));
          check("stream_instr", 64'(deq_instr), 64'(instr_of(exp_q[0])));
          void'(exp_q.pop_front());
        end
      end
      if (i < 10) exp_q.push_back(PC_W'(4 * (i + 1)));
      step();
    end
    check("stream_sb_empty", 64'(exp_q.size()), 64'd0);
    check("stream_end_empty", 64'(empty), 64'd1);

    // Simultaneous enqueue and dequeue at count 2
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h104, 1'b0, 1'b0);
    step();
    check("pair_count_before", 64'(count), 64'd2);
    drive(1'b1, 32'h108, 1'b1, 1'b0);
    step();
    check("pair_count_after", 64'(count), 64'd2);
    check("pair_head", 64'(deq_npc), 64'h104);

    // Flush wins over same-cycle enqueue and dequeue
    drive(1'b1, 32'h10C, 1'b0, 1'b0);
    step();
    check("preflush_count", 64'(count), 64'd3);
    drive(1'b1, 32'h40, 1'b1, 1'b1);
    step();
    check_idle("flush");
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    step();
    check("postflush_npc", 64'(deq_npc), 64'h44);
    check("postflush_count", 64'(count), 64'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("postflush_empty", 64'(empty), 64'd1);

    // Asynchronous reset between edges at count 2
    drive(1'b1, 32'hA0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hA4, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("prereset_count", 64'(count), 64'd2);
    #2;
    nRST = 1'b0;
    #1;
    check_idle("async_reset");
    step();
    nRST = 1'b1;
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("rereset_npc", 64'(deq_npc), 64'h4);
    check("rereset_count", 64'(count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop so a stuck run still reports
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch queue that replaces the single-entry IF/ID latch between Fetch and Decode. It holds up to DEPTH {next-PC, instruction} pairs with a valid/ready handshake on both sides, so Fetch can run ahead of a stalled Decode. It supports a synchronous flush for branch and jump squash, and presents all-zero words (a NOP) on its outputs whenever it holds nothing.

## Interface
Parameters:
- PC_W, 32, width of the next-PC field.
- INSTR_W, 32, width of the instruction field.
- DEPTH, 4, number of entries. Must be a power of two and at least 2.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous squash of every entry; highest priority.
- enq_valid  in  1  Fetch offers an entry.
- enq_ready  out  1  queue can accept an entry; equals !full.
- enq_npc  in  PC_W  next-PC of the offered entry.
- enq_instr  in  INSTR_W  instruction word of the offered entry.
- deq_valid  out  1  head entry is valid; equals !empty.
- deq_ready  in  1  Decode consumes the head entry this cycle.
- deq_npc  out  PC_W  head next-PC; 0 when empty.
- deq_instr  out  INSTR_W  head instruction; 0 when empty.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- Storage: circular buffer of DEPTH entries, each {npc, instr}.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Index = low bits of the pointer.
  - empty when wr_ptr == rd_ptr.
  - full when indices are equal and MSBs differ.
  - count = wr_ptr - rd_ptr, modulo 2^(ptr width).
- Enqueue fire: enq_valid && enq_ready && !flush.
  - Writes the entry at wr_ptr index.
  - Increments wr_ptr.
- Dequeue fire: deq_valid && deq_ready && !flush.
  - Increments rd_ptr.
  - deq_ready while empty is ignored.
- Simultaneous enqueue and dequeue fires: both pointers advance and count is unchanged.
  - This is legal at any occupancy except full.
  - When full, enq_ready = 0 regardless of deq_ready; there is no pass-through.
- enq_valid while full: the entry is not accepted. Fetch must hold it; the queue drops nothing.
- Flush (sampled at the clock edge):
  - wr_ptr and rd_ptr both return to 0.
  - Any same-cycle enqueue or dequeue is discarded.
  - The next cycle shows empty = 1, count = 0, deq_npc/deq_instr = 0.
- Output data: deq_npc and deq_instr are driven from the head entry, muxed to 0 when empty. Decode therefore sees a NOP on empty, matching the flush/bubble convention.
- Storage contents are not cleared on flush. Only the pointers reset, and the empty mux guarantees the zero outputs.

## Timing
- Reset (nRST low, asynchronous):
  - Pointers = 0 and all storage = 0.
  - Outputs: enq_ready = 1, deq_valid = 0, deq_npc = 0, deq_instr = 0, count = 0, full = 0, empty = 1.
- Reset asserted mid-operation: all entries are lost immediately, without waiting for a clock edge.
- Latency: an entry enqueued at edge N appears on deq_* after edge N, i.e. valid in cycle N+1. Minimum fall-through is 1 cycle; there is no combinational path from enq_* to deq_*.
- Throughput: 1 entry per cycle in each direction, sustained at any occupancy between 1 and DEPTH-1.
- Output derivation:
  - enq_ready, full, empty, count and deq_valid depend only on registered pointers. No path exists from any input port to these outputs.
  - deq_npc/deq_instr are a mux of registered storage.
- Wrap-around: pointers wrap modulo 2·DEPTH. Behaviour is identical across the wrap boundary.
- Stall: deq_ready = 0 holds the head entry and deq_* stable for any number of cycles.

## Test plan
- Reset then idle:
  - Stimulus: nRST low for 2 cycles, then release with no traffic.
  - Response: empty = 1, count = 0, enq_ready = 1, deq_valid = 0, deq_npc = deq_instr = 0 on every cycle.
- Fill and stall (DEPTH = 4):
  - Stimulus: enqueue npc 0x4, 0x8, 0xC, 0x10 on consecutive cycles, deq_ready = 0, keep enq_valid high with npc 0x14.
  - Response: count reaches 4, full = 1, enq_ready = 0; 0x14 is not accepted; deq_npc holds 0x4.
- Drain order and wrap:
  - Stimulus: continuous enq and deq for 10 entries with npc 0x4·k.
  - Response: deq_npc sequence 0x4, 0x8 … 0x28 in order, count steady at 1, no loss across the pointer wrap.
- Simultaneous enqueue and dequeue at count 2:
  - Stimulus: enqueue and dequeue fires in the same cycle.
  - Response: count stays 2; the head advances to the next entry.
- Flush with enqueue:
  - Stimulus: at count 3, assert flush together with enq_valid (npc 0x40) and deq_ready.
  - Response: next cycle count = 0, empty = 1, deq_instr = 0. A later enqueue of 0x44 appears as the first deq_npc.
- Asynchronous reset mid-stream:
  - Stimulus: drop nRST between edges at count 2.
  - Response: outputs return to the reset values before the next edge; 0x4 is the first output after re-enqueue.
